pipelined_signed_shift_or_divide: RTL and testbench
===================================================

// Module: pipelined_signed_shift_or_divide
//
// PURPOSE
//   Pipelined, run-time-variable signed right shift for N-bit two's-complement data.
//   Each transaction selects one of two modes:
//   - Arithmetic shift right (>>>): rounds toward -inf.
//   - Signed divide by 2**shift: rounds toward zero.
//   Sits in the arithmetic datapath wherever a scaled signed value is needed once per clock.
//   Fully pipelined with a valid-only handshake: one result per clock, fixed latency.
//
// PARAMETERS
//   N   8            data width in bits, N >= 2
//   SW  $clog2(N)    shift-amount width (derived, do not override)
//   LAT SW + 1       latency in clocks from arg_vld to res_vld (derived, do not override)
//
// PORTS
//   clk      in   1    clock, all logic on posedge
//   rst      in   1    synchronous reset, active-high
//   arg_vld  in   1    arg/shift/mode valid this cycle
//   arg      in   N    signed dividend / shift operand
//   shift    in   SW   shift amount s, unsigned
//   mode     in   1    0 = arithmetic shift (floor), 1 = signed divide (trunc toward 0)
//   res_vld  out  1    res valid this cycle
//   res      out  N    signed result
//
// BEHAVIOUR
// - Reset: one clock, synchronous, active-high (clk, rst).
//   rst=1 at posedge clears every stage valid bit, res_vld and res to 0.
//   In-flight transactions are dropped and never emerge after rst deasserts.
// - Handshake: no backpressure; every arg_vld=1 cycle is accepted.
//   The matching res_vld=1 appears exactly LAT clocks later.
//   Bubbles are preserved and results stay in order.
//   Stage data may hold stale values when the stage valid bit is 0.
// - Pipeline: SW registered barrel stages, then one correction stage.
//   Stage k (k = 0..SW-1):
//   - if s[k], shift the data right by 2**k, filling with the sign bit of arg;
//   - OR every bit shifted out into a sticky flag;
//   - carry sign, sticky and mode forward with the data.
//   Correction stage: res = shifted + (mode & sign & sticky).
//   The +1 can never overflow: a negative shift result is <= -1.
// - Arithmetic: res = floor(arg / 2**s) when mode=0; res = trunc(arg / 2**s) when mode=1.
//   No intermediate wider than N bits except the 1-bit sticky flag.
// - Boundaries:
//   - s = 0: res = arg in both modes; sticky = 0.
//   - s >= N (reachable only when N is not a power of 2):
//     - mode 0: all sign bits;
//     - mode 1: 0 (sticky set for any nonzero arg).
//   - arg = -2**(N-1), s = N-1: res = -1 in both modes.
//   - Exact multiples (sticky = 0): both modes give identical results.
//   - Positive arg: both modes give identical results.
// - No combinational path from any input to any output.
//
// TESTING  (N=8, LAT=4)
// 1. arg=0x96 (-106), s=3: mode0 -> res=0xF2 (-14); mode1 -> res=0xF3 (-13), 4 clk later.
// 2. arg=0xF8 (-8), s=3 -> 0xFF in both modes. arg=0x75 (117), s=2 -> 0x1D in both modes.
// 3. arg=0x80, s=7 -> 0xFF in both modes.
//    arg=0x81, s=7: mode0 -> 0xFF; mode1 -> 0x00. s=0 -> res=arg.
// 4. 200 back-to-back random (arg, s, mode) ->
//    res_vld high 4 clk after each arg_vld, in order;
//    res matches model $signed(arg)>>>s or $signed(arg)/(2**s).
// 5. arg_vld pattern 1,0,1,1,0,1 -> identical res_vld pattern delayed 4 clk, correct data.
// 6. rst=1 for 1 clk with 3 transactions in flight ->
//    res_vld=0 and res=0 the next clk; no res_vld until a new arg_vld after rst release.

Source files
------------

// File: rtl/pipelined_signed_shift_or_divide_if.sv
// Valid-only operand/result bundle for the pipelined signed shift/divide unit.
interface pipelined_signed_shift_or_divide_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned SW = $clog2(N)
) ();
    logic          arg_vld;
    logic [N-1:0]  arg;
    logic [SW-1:0] shift;
    logic          mode;
    logic          res_vld;
    logic [N-1:0]  res;

    modport master (
        output arg_vld, arg, shift, mode,
        input  res_vld, res
    );

    modport slave (
        input  arg_vld, arg, shift, mode,
        output res_vld, res
    );
endinterface

// File: rtl/pipelined_signed_shift_or_divide.sv
// Pipelined signed right shift: mode 0 floors (>>>), mode 1 truncates toward zero.
// SW barrel stages plus one correction stage give a latency of SW + 1 clocks.
module pipelined_signed_shift_or_divide #(
    parameter int unsigned N = 8
) (
    input logic clk,
    input logic rst,
    pipelined_signed_shift_or_divide_if.slave bus
);
    localparam int unsigned SW = $clog2(N);

    // Stage-k inputs: stage 0 reads the bus, later stages read the previous register.
    logic [N-1:0]  in_dat [SW];
    logic [SW-1:0] in_sh  [SW];
    logic [SW-1:0] in_sign, in_sticky, in_mode, in_vld;

    logic [N-1:0]  dat_d [SW];
    logic [SW-1:0] sticky_d;

    logic [N-1:0]  dat_q [SW];
    logic [SW-1:0] sh_q  [SW];
    logic [SW-1:0] sign_q, sticky_q, mode_q, vld_q;

    always_comb begin
        in_sign      = '0;
        in_sticky    = '0;
        in_mode      = '0;
        in_vld       = '0;
        in_dat[0]    = bus.arg;
        in_sh[0]     = bus.shift;
        in_sign[0]   = bus.arg[N-1];
        in_sticky[0] = 1'b0;
        in_mode[0]   = bus.mode;
        in_vld[0]    = bus.arg_vld;
        for (int k = 1; k < SW; k++) begin
            in_dat[k]    = dat_q[k-1];
            in_sh[k]     = sh_q[k-1];
            in_sign[k]   = sign_q[k-1];
            in_sticky[k] = sticky_q[k-1];
            in_mode[k]   = mode_q[k-1];
            in_vld[k]    = vld_q[k-1];
        end
    end

    // Stage k shifts by 2**k; 2**k < N always holds, so the shifted-out mask is never full.
    always_comb begin
        sticky_d = '0;
        for (int k = 0; k < SW; k++) begin
            dat_d[k]    = in_dat[k];
            sticky_d[k] = in_sticky[k];
            if (in_sh[k][k]) begin
                dat_d[k]    = $signed(in_dat[k]) >>> (1 << k);
                sticky_d[k] = in_sticky[k] | (|(in_dat[k] & ~({N{1'b1}} << (1 << k))));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= in_vld;
        end
        dat_q    <= dat_d;
        sh_q     <= in_sh;
        sign_q   <= in_sign;
        sticky_q <= sticky_d;
        mode_q   <= in_mode;
    end

    // A negative floor result is at most -1, so the +1 toward zero cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res_vld <= 1'b0;
            bus.res     <= '0;
        end else begin
            bus.res_vld <= vld_q[SW-1];
            bus.res     <= dat_q[SW-1] + N'(mode_q[SW-1] & sign_q[SW-1] & sticky_q[SW-1]);
        end
    end
endmodule

// File: tb/tb_pipelined_signed_shift_or_divide.sv
// Directed and random checks of the signed shift/divide pipeline at N=8 (latency 4).
module tb_pipelined_signed_shift_or_divide;
    localparam int unsigned N   = 8;
    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipelined_signed_shift_or_divide_if #(.N(N)) bus ();

    pipelined_signed_shift_or_divide #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.arg_vld = 1'b0;
        bus.arg     = '0;
        bus.shift   = '0;
        bus.mode    = 1'b0;
    endtask

    task automatic drive(input logic [7:0] a, input logic [2:0] s, input logic m);
        bus.arg_vld = 1'b1;
        bus.arg     = a;
        bus.shift   = s;
        bus.mode    = m;
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input logic [2:0] s, input logic m);
        int ai;
        ai = int'($signed(a));
        if (m) return 8'(ai / (1 << s));
        return 8'(ai >>> s);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        checks++;
        if (bus.res_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld: res_vld=%b expected 0", bus.res_vld);
        end
        checks++;
        if (bus.res !== 8'h00) begin
            errors++;
            $display("FAIL reset_res: res=%h expected 00", bus.res);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_directed();
        logic [7:0] ta [12] = '{8'h96, 8'h96, 8'hF8, 8'hF8, 8'h75, 8'h75,
                                8'h80, 8'h80, 8'h81, 8'h81, 8'h96, 8'h96};
        logic [2:0] ts [12] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2,
                                3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0};
        logic       tm [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] te [12] = '{8'hF2, 8'hF3, 8'hFF, 8'hFF, 8'h1D, 8'h1D,
                                8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h96, 8'h96};
        for (int i = 0; i < 12; i++) begin
            drive(ta[i], ts[i], tm[i]);
            for (int j = 0; j < LAT - 1; j++) begin
                cyc();
                idle();
                checks++;
                if (bus.res_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL directed_early[%0d]: res_vld=%b expected 0 at cycle %0d",
                             i, bus.res_vld, j);
                end
            end
            cyc();
            checks++;
            if (bus.res_vld !== 1'b1) begin
                errors++;
                $display("FAIL directed_vld[%0d]: res_vld=%b expected 1", i, bus.res_vld);
            end
            checks++;
            if (bus.res !== te[i]) begin
                errors++;
                $display("FAIL directed_res[%0d]: arg=%h s=%0d mode=%b res=%h expected %h",
                         i, ta[i], ts[i], tm[i], bus.res, te[i]);
            end
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        localparam int Num = 200;
        logic [7:0] ea [Num];
        logic [7:0] a;
        logic [2:0] s;
        logic       m;
        for (int c = 0; c < Num + int'(LAT); c++) begin
            if (c < Num) begin
                a = 8'($urandom);
                s = 3'($urandom_range(0, 7));
                m = 1'($urandom);
                ea[c] = model(a, s, m);
                drive(a, s, m);
            end else begin
                idle();
            end
            cyc();
            if (c >= 3 && c - 3 < Num) begin
                checks++;
                if (bus.res_vld !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_vld[%0d]: res_vld=%b expected 1", c - 3, bus.res_vld);
                end
                checks++;
                if (bus.res !== ea[c-3]) begin
                    errors++;
                    $display("FAIL b2b_res[%0d]: res=%h expected %h", c - 3, bus.res, ea[c-3]);
                end
            end else begin
                checks++;
                if (bus.res_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle[%0d]: res_vld=%b expected 0", c, bus.res_vld);
                end
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_bubbles();
        logic       pv [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] pa [6] = '{8'h96, 8'h11, 8'h81, 8'hC3, 8'h22, 8'h7F};
        logic [2:0] ps [6] = '{3'd3, 3'd1, 3'd7, 3'd2, 3'd1, 3'd4};
        logic       pm [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] pe [6] = '{8'hF3, 8'h00, 8'hFF, 8'hF1, 8'h00, 8'h07};
        logic       ev;
        for (int c = 0; c < 6 + int'(LAT); c++) begin
            if (c < 6) begin
                drive(pa[c], ps[c], pm[c]);
                bus.arg_vld = pv[c];
            end else begin
                idle();
            end
            cyc();
            ev = (c >= 3 && c - 3 < 6) ? pv[c-3] : 1'b0;
            checks++;
            if (bus.res_vld !== ev) begin
                errors++;
                $display("FAIL bubble_vld[%0d]: res_vld=%b expected %b", c, bus.res_vld, ev);
            end
            if (ev) begin
                checks++;
                if (bus.res !== pe[c-3]) begin
                    errors++;
                    $display("FAIL bubble_res[%0d]: res=%h expected %h", c - 3, bus.res, pe[c-3]);
                end
            end
        end
        cyc();
    endtask

    task automatic test_reset_in_flight();
        drive(8'h40, 3'd1, 1'b0);
        cyc();
        drive(8'h96, 3'd3, 1'b1);
        cyc();
        drive(8'h75, 3'd2, 1'b0);
        cyc();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (bus.res_vld !== 1'b0) begin
            errors++;
            $display("FAIL flight_rst_vld: res_vld=%b expected 0", bus.res_vld);
        end
        checks++;
        if (bus.res !== 8'h00) begin
            errors++;
            $display("FAIL flight_rst_res: res=%h expected 00", bus.res);
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if (bus.res_vld !== 1'b0) begin
                errors++;
                $display("FAIL flight_drop[%0d]: res_vld=%b expected 0", i, bus.res_vld);
            end
        end
        drive(8'hF8, 3'd3, 1'b1);
        for (int j = 0; j < LAT - 1; j++) begin
            cyc();
            idle();
            checks++;
            if (bus.res_vld !== 1'b0) begin
                errors++;
                $display("FAIL flight_new_early[%0d]: res_vld=%b expected 0", j, bus.res_vld);
            end
        end
        cyc();
        checks++;
        if (bus.res_vld !== 1'b1 || bus.res !== 8'hFF) begin
            errors++;
            $display("FAIL flight_new: res_vld=%b res=%h expected 1 ff", bus.res_vld, bus.res);
        end
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_directed();
        test_back_to_back();
        test_bubbles();
        test_reset_in_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
